// File: rtl/rv32_fetch_queue.sv
// rtl/rv32_fetch_queue.sv - RV32 instruction prefetch queue with in-flight tracking and redirect flush
module rv32_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          PW  = $clog2(DEPTH);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   push_pc_q, push_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [31:0]   epc_q  [DEPTH];
    logic [31:0]   epc_d  [DEPTH];

    logic        grant, resp, push, pop, head_valid;
    logic [31:0] redir_pc;
    logic        unused_redir_bits;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redir_pc          = {redirect_pc_i[31:2], 2'b00};
    assign unused_redir_bits = ^redirect_pc_i[1:0];

    // Credits cover both buffered words and words still in flight, so a push never finds the FIFO full.
    assign imem_req_o  = !rst_i && !redirect_i && (({1'b0, count_q} + {1'b0, outst_q}) < CAP);
    assign imem_addr_o = pc_q;

    assign grant      = imem_req_o && imem_gnt_i;
    assign resp       = imem_rvalid_i && (outst_q != '0);
    assign push       = resp && (discard_q == '0) && !redirect_i;
    assign head_valid = (count_q != '0);
    assign pop        = head_valid && instr_ready_i && !redirect_i;

    assign instr_valid_o = head_valid;
    assign instr_data_o  = head_valid ? data_q[head_q] : NOP;
    assign instr_pc_o    = head_valid ? epc_q[head_q] : 32'h0;

    always_comb begin
        pc_d      = pc_q;
        push_pc_d = push_pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        data_d    = data_q;
        epc_d     = epc_q;
        discard_d = discard_q;
        outst_d   = outst_q + CW'(grant) - CW'(resp);
        count_d   = count_q + CW'(push) - CW'(pop);

        if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        if (resp && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (push) begin
            data_d[tail_q] = imem_rdata_i;
            epc_d[tail_q]  = push_pc_q;
            tail_d         = wrap_inc(tail_q);
            push_pc_d      = push_pc_q + 32'd4;
        end
        if (pop) begin
            head_d = wrap_inc(head_q);
        end
        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect_i) begin
            pc_d      = redir_pc;
            push_pc_d = redir_pc;
            count_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            discard_d = outst_q - CW'(resp);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            push_pc_q <= RESET_PC;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            push_pc_q <= push_pc_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        epc_q  <= epc_d;
    end
endmodule

// File: tb/tb_rv32_fetch_queue.sv
// tb/tb_rv32_fetch_queue.sv - scoreboard bench for rv32_fetch_queue
module tb_rv32_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        req, valid, req2, valid2;
    logic [31:0] addr, data, pc, addr2, data2, pc2;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] mix = 32'h0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_data_q[$];
    int          due_q[$];
    logic [31:0] maddr_q[$];

    rv32_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .instr_valid_o(valid), .instr_data_o(data), .instr_pc_o(pc),
        .instr_ready_i(ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
    );

    rv32_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .instr_valid_o(valid2), .instr_data_o(data2), .instr_pc_o(pc2),
        .instr_ready_i(ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic exp_item(input logic [31:0] p);
        exp_pc_q.push_back(p);
        exp_data_q.push_back(p ^ mix);
    endtask

    // Memory: fixed latency, in-order, returns address ^ mix.
    always @(negedge clk) begin
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            rvalid = 1'b1;
            rdata  = maddr_q[0] ^ mix;
            void'(due_q.pop_front());
            void'(maddr_q.pop_front());
        end
        if (req && gnt) begin
            due_q.push_back(cyc + lat);
            maddr_q.push_back(addr);
        end
    end

    always @(negedge clk) begin
        if (!rst && valid && ready && !redirect) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected none", pc);
            end else begin
                chk("instr_pc", pc, exp_pc_q.pop_front());
                chk("instr_data", data, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 32'h13);
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr2", addr2, 32'hFFFF_FFFC);

        // streaming, 1-cycle memory
        mix = 32'h0; lat = 1; gnt = 1; ready = 1;
        for (int i = 0; i < 8; i++) exp_item(32'(i * 4));
        do_reset();
        #1;
        chk("t1_req_c0", req, 1);
        chk("t1_addr_c0", addr, 32'h0);
        chk("t1_req2_c0", req2, 1);
        chk("t1_addr2_c0", addr2, 32'hFFFF_FFFC);
        chk("t1_valid_c0", valid, 0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 8) gnt = 0;
            #1;
            if (k == 1) begin
                chk("t1_valid_c1", valid, 0);
                chk("t1_addr2_c1", addr2, 32'h0);
            end
            if (k >= 2 && k <= 9) chk("t1_stream_valid", valid, 1);
            if (k == 2) begin
                chk("t1_valid2_c2", valid2, 1);
                chk("t1_pc2_c2", pc2, 32'hFFFF_FFFC);
                chk("t1_data2_c2", data2, 32'h0);
            end
            if (k == 3) chk("t1_pc2_c3", pc2, 32'h0);
        end
        chk("t1_drained", exp_pc_q.size(), 0);
        chk("t1_valid_end", valid, 0);

        // backpressure fills the credits
        mix = 32'h5A5A_0000; lat = 1; gnt = 1; ready = 0;
        for (int i = 0; i < 6; i++) exp_item(32'(i * 4));
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 8) begin ready = 1; gnt = 0; end
            if (k == 9) gnt = 1;
            if (k == 11) gnt = 0;
            #1;
            if (k == 4 || k == 7) begin
                chk("t2_req_full", req, 0);
                chk("t2_addr_hold", addr, 32'h10);
            end
            if (k == 7) chk("t2_valid_held", valid, 1);
            if (k == 9) begin
                chk("t2_req_resume", req, 1);
                chk("t2_addr_resume", addr, 32'h10);
            end
        end
        chk("t2_drained", exp_pc_q.size(), 0);
        chk("t2_valid_end", valid, 0);

        // grant stall
        gnt = 0; ready = 1;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t3_req_stall", req, 1);
            chk("t3_addr_stall", addr, 32'h0);
            chk("t3_valid_stall", valid, 0);
        end

        // redirect with two in flight, 3-cycle latency
        mix = 32'h0F0F_0000; lat = 3; gnt = 1; ready = 1;
        exp_item(32'h100);
        exp_item(32'h104);
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) begin gnt = 0; redirect = 1; redirect_pc = 32'h103; end
            if (k == 3) begin redirect = 0; gnt = 1; end
            if (k == 5) gnt = 0;
            #1;
            if (k == 2) chk("t4_req_redirect", req, 0);
            if (k == 3) begin
                chk("t4_req_new", req, 1);
                chk("t4_addr_new", addr, 32'h100);
            end
            if (k >= 3 && k <= 6) chk("t4_valid_dropped", valid, 0);
            if (k == 7) chk("t4_valid_new", valid, 1);
        end
        chk("t4_drained", exp_pc_q.size(), 0);

        // redirect with a full FIFO
        mix = 32'h3333_0000; lat = 1; gnt = 1; ready = 0;
        exp_item(32'h200);
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) gnt = 0;
            if (k == 5) begin redirect = 1; redirect_pc = 32'h200; end
            if (k == 6) begin redirect = 0; gnt = 1; ready = 1; end
            if (k == 7) gnt = 0;
            #1;
            if (k == 5) begin
                chk("t5_req_redirect", req, 0);
                chk("t5_valid_full", valid, 1);
            end
            if (k == 6) begin
                chk("t5_valid_flushed", valid, 0);
                chk("t5_req_new", req, 1);
                chk("t5_addr_new", addr, 32'h200);
            end
        end
        chk("t5_drained", exp_pc_q.size(), 0);

        // reset pulse with 2 in flight and 2 buffered
        mix = 32'h4444_0000; lat = 2; gnt = 1; ready = 0;
        exp_item(32'h0);
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 4) rst = 1;
            if (k == 5) begin rst = 0; gnt = 0; end
            if (k == 6) begin gnt = 1; ready = 1; end
            if (k == 7) gnt = 0;
            #1;
            if (k == 4) chk("t6_req_rst", req, 0);
            if (k == 5) begin
                chk("t6_valid_after_rst", valid, 0);
                chk("t6_req_restart", req, 1);
                chk("t6_addr_restart", addr, 32'h0);
            end
            if (k == 6) begin
                chk("t6_late_ignored", valid, 0);
                chk("t6_addr_hold", addr, 32'h0);
            end
        end
        chk("t6_drained", exp_pc_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32_fetch_queue.md
# rv32_fetch_queue

Instruction prefetch stage that sits directly upstream of the RV32 core. It generates sequential fetch addresses to instruction memory and tracks in-flight requests. Returned words are buffered in a small in-order FIFO and presented to the core with a valid/ready handshake. A redirect input flushes the FIFO, discards responses still in flight, and restarts fetch at a new PC.

## Interface
- DEPTH, 4: FIFO entries; also the cap on (FIFO occupancy + outstanding requests); legal range 2..16
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle (valid only while imem_req_o=1)
- imem_rvalid_i  in  1  response word valid; responses return in request order, ≥1 cycle after grant
- imem_rdata_i  in  32  response instruction word
- instr_valid_o  out  1  FIFO head valid
- instr_data_o  out  32  FIFO head instruction; feeds core instruction input
- instr_pc_o  out  32  address of FIFO head instruction
- instr_ready_i  in  1  core consumes head this cycle
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  32  new fetch PC; bits [1:0] forced to 0

## Operation
- State: fetch PC register, FIFO (data + pc per entry), occupancy count, outstanding counter, discard counter (all wide enough for DEPTH).
- imem_req_o = !rst_i && !redirect_i && (count + outstanding < DEPTH); combinational, no dependence on gnt.
- imem_addr_o = fetch PC; held stable while req=1 and gnt=0.
- Grant (req && gnt): PC <= PC+4 (mod 2^32 wrap), outstanding += 1.
- Response (rvalid): outstanding -= 1; if discard > 0 then discard -= 1 and word dropped, else push {rdata, pc-of-request} to FIFO tail. Pushed pc tracked via a second counter advanced on each accepted push, reloaded on redirect.
- Pop (instr_valid_o && instr_ready_i): advance head.
- Empty FIFO: instr_valid_o=0, instr_data_o=32'h0000_0013 (ADDI x0,x0,0 NOP), instr_pc_o=0.
- rvalid while outstanding=0: protocol violation, ignored, no state change.
- Redirect (redirect_i=1): FIFO cleared (any pop that cycle is void), PC <= {redirect_pc_i[31:2],2'b00}, discard <= outstanding − rvalid (pending responses after this cycle), outstanding unchanged except for this cycle's rvalid; no request issued that cycle.
- Redirect while discard > 0: discard accumulates to total remaining outstanding.
- Credit check makes push-into-full impossible; no FIFO bypass (pushed word visible next cycle).
- Reset: PC=RESET_PC, FIFO empty, count/outstanding/discard=0.

## Timing
- Reset values of outputs: imem_req_o=0 (while rst_i high), imem_addr_o=RESET_PC, instr_valid_o=0, instr_data_o=32'h0000_0013, instr_pc_o=0.
- Cycle 0 = first cycle with rst_i low: req=1, addr=RESET_PC.
- With gnt in cycle 0 and rvalid in cycle 1: instr_valid_o=1 in cycle 2 (3-cycle reset-to-first-instruction).
- Sustained one instruction per cycle with 1-cycle memory latency and ready=1 for DEPTH≥3.
- Redirect in cycle N: req=1 with new PC in cycle N+1 (if credits allow); instr_valid_o=0 in N+1.
- Reset asserted mid-operation: all state cleared on next edge; late responses after reset are ignored because outstanding=0.

## Test plan
- Reset release, gnt=1, 1-cycle rvalid, ready=1, memory returns word=addr: instr_pc_o 0x0,0x4,0x8… from cycle 2, one per cycle, instr_data_o equals pc.
- ready=0 held: exactly 4 grants (addr 0x0–0xC), then req=0, imem_addr_o=0x10 stable; ready=1 drains 0x0,0x4,0x8,0xC in order, then fetch resumes at 0x10.
- Memory latency 3 cycles, 2 outstanding, redirect to 0x103: both late responses dropped, next request addr 0x100, first valid instr_pc_o=0x100.
- gnt=0 for 5 cycles with req=1: imem_addr_o stable, no outstanding increment, instr_valid_o stays 0.
- RESET_PC=0xFFFF_FFFC: request addresses 0xFFFF_FFFC then 0x0000_0000, pcs delivered in the same order.
- rst_i pulsed with 2 outstanding and 2 FIFO entries: instr_valid_o=0 next cycle, late rvalid ignored, fetch restarts at RESET_PC.
